nibble_add_seq: RTL and testbench
=================================

Name: nibble_add_seq

Overview:
- Multi-cycle controller that computes wide add/subtract (4*NIBBLES bits) by time-sharing one external 4-bit adder, the add4b1 block.
- add4b1 ports: sum[3:0], cout, a[3:0], b[3:0]. It has no carry-in.
- Carry is therefore injected with a second adder pass per nibble.
- Sits between a requesting datapath (start/done handshake) and the shared add4b1 instance.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand (operand width = 4*NIBBLES); legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_sub  input  1  0 = opa+opb, 1 = opa-opb; latched with start
- opa  input  4*NIBBLES  operand A; latched with start
- opb  input  4*NIBBLES  operand B; latched with start
- busy  output  1  high in PH0/PH1/DONE
- done  output  1  one-cycle pulse; result/cout valid
- result  output  4*NIBBLES  final sum/difference; held until next completion
- cout  output  1  final carry (subtract: 1 = no borrow)
- add_a  output  4  to add4b1 a
- add_b  output  4  to add4b1 b
- add_sum  input  4  from add4b1 sum
- add_cout  input  1  from add4b1 cout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, result=0, cout=0, done=0, busy=0, add_a=0, add_b=0. Takes effect immediately, including mid-operation; the partial result is discarded and no done pulse is issued.
- States: IDLE, PH0, PH1, DONE.
- IDLE:
  - start=1 at an edge: latch opa into A_reg.
  - Latch B_reg = op_sub ? ~opb : opb.
  - carry <= op_sub, idx <= 0, go to PH0.
  - start=0: stay in IDLE.
- PH0 (combinational drive):
  - add_a = A_reg nibble idx, add_b = B_reg nibble idx.
  - At the edge: s_tmp <= add_sum, c0 <= add_cout. Go to PH1.
- PH1 (combinational drive):
  - add_a = s_tmp, add_b = {3'b000, carry}.
  - At the edge: acc nibble idx <= add_sum; carry <= c0 | add_cout (both are never 1 together).
  - If idx == NIBBLES-1: result <= acc with the final nibble merged, cout <= new carry, go to DONE.
  - Else: idx <= idx+1, go to PH0.
- PH1 always runs, even when carry=0, so latency is fixed.
- DONE: done=1 for exactly this cycle, busy=1. Next edge goes to IDLE.
- add_a/add_b = 0 in IDLE and DONE.
- Latency: with start sampled at edge k, done is high in the cycle following edge k+2*NIBBLES. Throughput is one operation per 2*NIBBLES+2 cycles.
- start is ignored in PH0/PH1/DONE; there is no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- Operand inputs may change after the start edge without effect.
- Arithmetic:
  - result = (opa + (op_sub ? ~opb : opb) + op_sub) mod 2^(4*NIBBLES).
  - cout = bit 4*NIBBLES of that sum.
- idx width = clog2(NIBBLES), minimum 1. idx never exceeds NIBBLES-1.
- done and busy are registered-state decodes (no glitch from add_sum/add_cout).

Test Plan:
- Bench instantiates add4b1 wired to add_a/add_b/add_sum/add_cout, with NIBBLES=4.
- Add, no carry: opa=0x1234, opb=0x4321, op_sub=0, start for 1 cycle -> done pulses 1 cycle, 8 edges after the start edge; result=0x5555, cout=0; busy high for 9 cycles.
- Full ripple: opa=0xFFFF, opb=0x0001, add -> result=0x0000, cout=1. In PH1 for nibbles 1..3: add_a=0xF, add_b=0x1.
- Subtract: opa=0x5000, opb=0x0001, op_sub=1 -> result=0x4FFF, cout=1. Then opa=0x0000, opb=0x0001 -> result=0xFFFF, cout=0.
- Ignore while busy: pulse start with opa=0x1111/opb=0x1111 at edge k, then pulse start with 0x2222/0x2222 at edge k+3 -> exactly one done, result=0x2222, no second done.
- Reset mid-operation: assert rst_n=0 asynchronously during PH1 of nibble 2 -> busy/done/result/cout go to 0 immediately. After release, start 0x0F0F+0x00F1 -> result=0x1000, cout=0.
- Hold start high continuously with fixed operands 0x8000+0x8000 -> done pulses every 10 cycles; result=0x0000, cout=1 each time.

Source files
------------

// File: rtl/nibble_add_seq.sv
// Wide add/subtract built from one shared 4-bit adder (add4b1) that has no carry-in.
// Each nibble takes two passes: operand add (PH0), then carry injection (PH1).
module nibble_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [4*NIBBLES-1:0] opa,
    input  logic [4*NIBBLES-1:0] opb,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPh0,
        StPh1,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [3:0]     s_tmp_q, s_tmp_d;
    logic           c0_q, c0_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic [IW+1:0]  nib_lsb;

    assign nib_lsb = {idx_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            s_tmp_q  <= '0;
            c0_q     <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_tmp_q  <= s_tmp_d;
            c0_q     <= c0_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        s_tmp_d  = s_tmp_q;
        c0_d     = c0_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        add_a    = 4'h0;
        add_b    = 4'h0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = opa;
                    // Subtract as A + ~B + 1; the +1 rides in as the initial carry.
                    b_d     = op_sub ? ~opb : opb;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = StPh0;
                end
            end
            StPh0: begin
                add_a   = a_q[nib_lsb +: 4];
                add_b   = b_q[nib_lsb +: 4];
                s_tmp_d = add_sum;
                c0_d    = add_cout;
                state_d = StPh1;
            end
            StPh1: begin
                add_a = s_tmp_q;
                add_b = {3'b000, carry_q};
                acc_d[nib_lsb +: 4] = add_sum;
                // At most one of the two passes can carry out, so OR is exact.
                carry_d = c0_q | add_cout;
                if (idx_q == LAST_IDX) begin
                    result_d = acc_d;
                    cout_d   = carry_d;
                    state_d  = StDone;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = StPh0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq (NIBBLES=4) with a behavioural add4b1 and an arithmetic model.
module tb_nibble_add_seq;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic [3:0]   add_sum;
    logic         add_cout;

    int total;
    int bad;

    logic [3:0] rec_a [0:63];
    logic [3:0] rec_b [0:63];

    nibble_add_seq #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .opa      (opa),
        .opb      (opb),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // add4b1: plain 4-bit adder without carry-in
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
        logic [W:0] bb;
        bb = sub ? {1'b0, ~b} : {1'b0, b};
        return {1'b0, a} + bb + {{W{1'b0}}, sub};
    endfunction

    // Launch one operation, wait for done (bounded), record adder drives per cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic [W-1:0] res, output logic co,
                          output int lat, output int bcnt);
        int cnt;
        @(negedge clk);
        opa = a; opb = b; op_sub = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opa = W'($urandom); opb = W'($urandom); op_sub = 1'($urandom);
        cnt = 1;
        bcnt = busy ? 1 : 0;
        rec_a[1] = add_a; rec_b[1] = add_b;
        while (!done && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (busy) bcnt++;
            rec_a[cnt] = add_a; rec_b[cnt] = add_b;
        end
        lat = done ? cnt : -1;
        res = result;
        co  = cout;
        @(negedge clk);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_res;
        logic         exp_cout;
    } vec_t;

    initial begin
        vec_t         vecs [0:4];
        logic [W-1:0] res;
        logic         co;
        logic [W:0]   m;
        int           lat;
        int           bcnt;
        int           ndone;
        int           dtimes [$];

        total = 0; bad = 0;
        start = 1'b0; op_sub = 1'b0; opa = '0; opb = '0;
        rst_n = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h5000, 16'h0001, 1'b1, 16'h4FFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

        #12;
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_cout",   {31'd0, cout},   32'd0);
        check("rst_add_a",  {28'd0, add_a},  32'd0);
        check("rst_add_b",  {28'd0, add_b},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, res, co, lat, bcnt);
            check($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].exp_res});
            check($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].exp_cout});
            check($sformatf("vec%0d_latency", i), lat, 2 * N + 1);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, 2 * N + 1);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            if (i == 1) begin
                // Carry-injection pass for nibbles 1..3 sees 0xF + 1
                for (int k = 1; k < 4; k++) begin
                    check($sformatf("ripple_ph1_a%0d", k), {28'd0, rec_a[2 * k + 2]}, 32'hF);
                    check($sformatf("ripple_ph1_b%0d", k), {28'd0, rec_b[2 * k + 2]}, 32'h1);
                end
            end
        end

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            m = model(ra, rb, rs);
            run_op(ra, rb, rs, res, co, lat, bcnt);
            check($sformatf("rnd%0d_result", i), {16'd0, res}, {16'd0, m[W-1:0]});
            check($sformatf("rnd%0d_cout", i), {31'd0, co}, {31'd0, m[W]});
            check($sformatf("rnd%0d_latency", i), lat, 2 * N + 1);
        end

        // start again at edge k+3 must be ignored
        @(negedge clk);
        opa = 16'h1111; opb = 16'h1111; op_sub = 1'b0; start = 1'b1;
        ndone = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = (n == 3);
            if (n == 3) begin opa = 16'h2222; opb = 16'h2222; end
            if (done) begin
                ndone++;
                check("ignore_result", {16'd0, result}, 32'h2222);
            end
        end
        start = 1'b0;
        check("ignore_done_count", ndone, 1);

        // asynchronous reset in PH1 of nibble 2
        @(negedge clk);
        opa = 16'h1234; opb = 16'h1111; op_sub = 1'b0; start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",   {31'd0, busy},   32'd0);
        check("midrst_done",   {31'd0, done},   32'd0);
        check("midrst_result", {16'd0, result}, 32'd0);
        check("midrst_cout",   {31'd0, cout},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0F0F, 16'h00F1, 1'b0, res, co, lat, bcnt);
        check("postrst_result", {16'd0, res}, 32'h1000);
        check("postrst_cout", {31'd0, co}, 32'd0);

        // start held high: one operation every 2N+2 cycles
        @(negedge clk);
        opa = 16'h8000; opb = 16'h8000; op_sub = 1'b0; start = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (done) begin
                dtimes.push_back(n);
                check("hold_result", {16'd0, result}, 32'h0000);
                check("hold_cout", {31'd0, cout}, 32'd1);
            end
        end
        start = 1'b0;
        check("hold_done_count", dtimes.size(), 4);
        for (int i = 1; i < dtimes.size(); i++)
            check("hold_period", dtimes[i] - dtimes[i - 1], 2 * N + 2);
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
